bcsa_err_monitor: RTL and testbench

- Downstream consumer of the 32-bit block carry-select approximate adder.
- Takes each operand pair plus the adder's approximate 33-bit sum over a valid/ready handshake.
- Recomputes the exact sum and accumulates error statistics over a programmed number of samples: error count, summed error distance, maximum error distance.
- Used by the characterisation harness to score approximate adder variants on-chip.

---
 rtl/bcsa_err_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_bcsa_err_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcsa_err_monitor.sv
// Error-statistics monitor for the block carry-select approximate adder: recomputes exact sums
// and accumulates error count, summed and maximum error distance. BCSA_ERRMON_WORST_EN adds worst_a/worst_b.
module bcsa_err_monitor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [WIDTH:0]   max_ed
`ifdef BCSA_ERRMON_WORST_EN
  ,
  output logic [WIDTH-1:0] worst_a,
  output logic [WIDTH-1:0] worst_b
`endif
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned ACC_X = ACC_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               clear;
  logic               accept;

  logic               v1_q, v1_d;
  logic [SUM_W-1:0]   exact_q, exact_d;
  logic [SUM_W-1:0]   approx_q, approx_d;
  logic               v2_q, v2_d;
  logic [SUM_W-1:0]   ed_q, ed_d;
  logic [SUM_W-1:0]   ed_c;

  logic [CNT_W-1:0]   err_q, err_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   max_q, max_d;
  logic [ACC_W:0]     sum_ext;

`ifdef BCSA_ERRMON_WORST_EN
  logic [WIDTH-1:0]   a1_q, a1_d, b1_q, b1_d;
  logic [WIDTH-1:0]   a2_q, a2_d, b2_q, b2_d;
  logic [WIDTH-1:0]   worst_a_q, worst_a_d, worst_b_q, worst_b_d;
`endif

  // Ready is a pure function of state so the producer may hold in_valid freely.
  assign in_ready = (state_q == ST_RUN) && (acc_cnt_q < num_q);
  assign accept   = in_valid && in_ready;

  assign ed_c    = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
  assign sum_ext = {1'b0, sum_q} + ACC_X'(ed_q);

  // Run control: start only honoured from IDLE/DONE; DRAIN exits as stage 2 retires.
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    num_d     = num_q;
    clear     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear     = 1'b1;
          num_d     = num_samples;
          acc_cnt_d = '0;
          state_d   = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == (num_q - CNT_W'(1))) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!v1_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  // Two-stage datapath: exact sum, then error distance, then statistics update.
  always_comb begin
    v1_d     = accept;
    exact_d  = exact_q;
    approx_d = approx_q;
    v2_d     = v1_q;
    ed_d     = ed_q;
    err_d    = err_q;
    sum_d    = sum_q;
    max_d    = max_q;
`ifdef BCSA_ERRMON_WORST_EN
    a1_d      = a1_q;
    b1_d      = b1_q;
    a2_d      = a2_q;
    b2_d      = b2_q;
    worst_a_d = worst_a_q;
    worst_b_d = worst_b_q;
`endif
    if (accept) begin
      exact_d  = SUM_W'(op_a) + SUM_W'(op_b);
      approx_d = approx_sum;
`ifdef BCSA_ERRMON_WORST_EN
      a1_d = op_a;
      b1_d = op_b;
`endif
    end
    if (v1_q) begin
      ed_d = ed_c;
`ifdef BCSA_ERRMON_WORST_EN
      a2_d = a1_q;
      b2_d = b1_q;
`endif
    end
    if (clear) begin
      err_d = '0;
      sum_d = '0;
      max_d = '0;
`ifdef BCSA_ERRMON_WORST_EN
      worst_a_d = '0;
      worst_b_d = '0;
`endif
    end else if (v2_q) begin
      if (ed_q != '0) begin
        err_d = err_q + CNT_W'(1);
      end
      sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (ed_q > max_q) begin
        max_d = ed_q;
`ifdef BCSA_ERRMON_WORST_EN
        worst_a_d = a2_q;
        worst_b_d = b2_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_cnt_q <= '0;
      num_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      v1_q      <= 1'b0;
      exact_q   <= '0;
      approx_q  <= '0;
      v2_q      <= 1'b0;
      ed_q      <= '0;
      err_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
`ifdef BCSA_ERRMON_WORST_EN
      a1_q      <= '0;
      b1_q      <= '0;
      a2_q      <= '0;
      b2_q      <= '0;
      worst_a_q <= '0;
      worst_b_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      num_q     <= num_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      v1_q      <= v1_d;
      exact_q   <= exact_d;
      approx_q  <= approx_d;
      v2_q      <= v2_d;
      ed_q      <= ed_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
`ifdef BCSA_ERRMON_WORST_EN
      a1_q      <= a1_d;
      b1_q      <= b1_d;
      a2_q      <= a2_d;
      b2_q      <= b2_d;
      worst_a_q <= worst_a_d;
      worst_b_q <= worst_b_d;
`endif
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = max_q;
`ifdef BCSA_ERRMON_WORST_EN
  assign worst_a   = worst_a_q;
  assign worst_b   = worst_b_q;
`endif

endmodule

// File: tb/tb_bcsa_err_monitor.sv
// Scoreboard bench for bcsa_err_monitor: default instance plus an ACC_W=33 instance sharing stimulus.
module tb_bcsa_err_monitor;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ACC_W = 48;
  localparam int unsigned ACC_S = 33;
  localparam longint unsigned SAT48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned SAT33 = 64'h0000_0001_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [WIDTH:0]   approx_sum = '0;

  logic             in_ready, busy, done;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [WIDTH:0]   max_ed;
  logic             in_ready_s, busy_s, done_s;
  logic [CNT_W-1:0] err_count_s;
  logic [ACC_S-1:0] sum_ed_s;
  logic [WIDTH:0]   max_ed_s;
`ifdef BCSA_ERRMON_WORST_EN
  logic [WIDTH-1:0] worst_a, worst_b, worst_a_s, worst_b_s;
`endif

  bcsa_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy), .done(done), .err_count(err_count),
    .sum_ed(sum_ed), .max_ed(max_ed)
`ifdef BCSA_ERRMON_WORST_EN
    , .worst_a(worst_a), .worst_b(worst_b)
`endif
  );

  bcsa_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy_s), .done(done_s), .err_count(err_count_s),
    .sum_ed(sum_ed_s), .max_ed(max_ed_s)
`ifdef BCSA_ERRMON_WORST_EN
    , .worst_a(worst_a_s), .worst_b(worst_b_s)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned err;
    longint unsigned sum;
    longint unsigned sum_s;
    longint unsigned mx;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;

  longint unsigned m_err, m_sum, m_sum_s, m_max;
  logic [WIDTH-1:0] m_wa, m_wb;
  int m_cnt, m_num;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int n);
    m_err = 0; m_sum = 0; m_sum_s = 0; m_max = 0;
    m_wa = '0; m_wb = '0;
    m_cnt = 0; m_num = n;
  endtask

  task automatic push_expect();
    exp_t e;
    e.err = m_err; e.sum = m_sum; e.sum_s = m_sum_s; e.mx = m_max;
    e.wa = m_wa; e.wb = m_wb;
    sb_q.push_back(e);
  endtask

  // Reference: exact sum and distance in 64-bit arithmetic, saturation by compare.
  task automatic model_sample(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH:0] ap);
    longint unsigned ex, apx, ed;
    ex  = 64'(a) + 64'(b);
    apx = 64'(ap);
    ed  = (ex >= apx) ? ex - apx : apx - ex;
    if (ed != 0) m_err++;
    m_sum   = (m_sum + ed > SAT48) ? SAT48 : m_sum + ed;
    m_sum_s = (m_sum_s + ed > SAT33) ? SAT33 : m_sum_s + ed;
    if (ed > m_max) begin
      m_max = ed; m_wa = a; m_wb = b;
    end
    m_cnt++;
    if (m_cnt == m_num) push_expect();
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    num_samples = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    model_reset(n);
    if (n == 0) push_expect();
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH:0] ap);
    int waited = 0;
    in_valid = 1'b1; op_a = a; op_b = b; approx_sum = ap;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      model_sample(a, b, ap);
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic rand_sample(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b,
                             output logic [WIDTH:0] ap);
    logic [WIDTH:0] ex;
    a  = $urandom;
    b  = $urandom;
    ex = {1'b0, a} + {1'b0, b};
    ap = ($urandom_range(0, 3) == 0) ? ex : (ex ^ (WIDTH+1)'($urandom_range(1, 1023)));
  endtask

  task automatic finish_run(input bit chk_lat);
    exp_t e;
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("done_seen_acc33", 64'(done_s), 64'd1);
    if (chk_lat) check("done_latency", 64'(cyc - acc_cyc), 64'd2);
    check("busy_at_done", 64'(busy), 64'd0);
    check("busy_at_done_acc33", 64'(busy_s), 64'd0);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("err_count", 64'(err_count), e.err);
      check("sum_ed", 64'(sum_ed), e.sum);
      check("max_ed", 64'(max_ed), e.mx);
      check("err_count_acc33", 64'(err_count_s), e.err);
      check("sum_ed_acc33", 64'(sum_ed_s), e.sum_s);
      check("max_ed_acc33", 64'(max_ed_s), e.mx);
`ifdef BCSA_ERRMON_WORST_EN
      check("worst_a", 64'(worst_a), 64'(e.wa));
      check("worst_b", 64'(worst_b), 64'(e.wb));
`endif
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_in_ready_acc33"}, 64'(in_ready_s), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_sum_ed"}, 64'(sum_ed), 64'd0);
    check({tag, "_max_ed"}, 64'(max_ed), 64'd0);
`ifdef BCSA_ERRMON_WORST_EN
    check({tag, "_worst_a"}, 64'(worst_a), 64'd0);
    check({tag, "_worst_b"}, 64'(worst_b), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   ap;
    int               stable_err;

    model_reset(0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_idle");

    // Exact samples, including carry out of the top bit.
    start_run(3);
    check("busy_after_start", 64'(busy), 64'd1);
    send(32'd5, 32'd3, 33'h0_0000_0008);
    send(32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000);
    send(32'h10, 32'h10, 33'h0_0000_0020);
    finish_run(1'b1);

    // Equal error distances: tie keeps the first sample as worst.
    start_run(2);
    send(32'h0F, 32'h01, 33'h0_0000_0000);
    send(32'h100, 32'h100, 33'h0_0000_0210);
    finish_run(1'b1);

    // Zero-sample run completes immediately and never offers ready.
    start_run(0);
    check("zero_run_done", 64'(done), 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("zero_run_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    finish_run(1'b0);

    // Sparse valid with an ignored mid-run start.
    start_run(4);
    for (int i = 0; i < 4; i++) begin
      rand_sample(a, b, ap);
      send(a, b, ap);
      if (i == 1) begin
        start = 1'b1;
        num_samples = CNT_W'(9);
      end
      if (i < 3) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("in_ready_after_last", 64'(in_ready), 64'd0);
    check("busy_in_drain", 64'(busy), 64'd1);
    in_valid = 1'b1; op_a = 32'h1234; op_b = 32'h1; approx_sum = '0;
    finish_run(1'b1);
    stable_err = int'(err_count);
    repeat (3) @(posedge clk);
    #1;
    check("done_frozen_err", 64'(err_count), 64'(stable_err));
    check("done_frozen_done", 64'(done), 64'd1);
    in_valid = 1'b0;

    // Saturating accumulator on the ACC_W=33 instance.
    start_run(3);
    for (int i = 0; i < 3; i++) send(32'd0, 32'd0, 33'h1_FFFF_FFFF);
    finish_run(1'b1);

    // Asynchronous reset mid-run after 2 of 5 samples.
    start_run(5);
    send(32'h20, 32'h1, 33'h0_0000_0000);
    send(32'h40, 32'h1, 33'h0_0000_0000);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_err_count", 64'(err_count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("post_reset");

    // Clean run after reset, back-to-back at full throughput.
    start_run(6);
    for (int i = 0; i < 6; i++) begin
      rand_sample(a, b, ap);
      send(a, b, ap);
      if (i == 0) first_cyc = acc_cyc;
    end
    check("back_to_back_cycles", 64'(acc_cyc - first_cyc), 64'd5);
    finish_run(1'b1);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
